alu: RTL and testbench

- Parameterised 8-bit (default) arithmetic/logic unit with registered outputs, used as the datapath execution element of the core.
- Operates on two operands and provides:
  - eight operations selected by a 3-bit opcode;
  - optional inversion of operand_1;
  - a carry chain input and output;
  - a zero flag.
- Outputs are updated on the rising clock edge: one-cycle latency from inputs to result/flags.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_shifter.sv | 31 +++
 rtl/alu.sv | 108 ++++++++++
 tb/tb_alu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the alu datapath element.
// Optional feature macro used by alu: ALU_OVERFLOW_FLAG_EN.
package alu_pkg;

    localparam int unsigned ALU_WIDTH_DEFAULT = 8;
    localparam int unsigned ALU_OP_W          = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_TEST        = 3'd0,
        ALU_OP_SUM         = 3'd1,
        ALU_OP_AND         = 3'd2,
        ALU_OP_OR          = 3'd3,
        ALU_OP_XOR         = 3'd4,
        ALU_OP_SHIFT_LEFT  = 3'd5,
        ALU_OP_SHIFT_RIGHT = 3'd6,
        ALU_OP_NOT         = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational bidirectional barrel shifter with zero fill and shift-out bit.
// Right shifts reuse the left-shift network by bit-reversing input and output.
module alu_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]         data,
    input  logic [$clog2(WIDTH)-1:0] amount,
    input  logic                     shift_right,
    output logic [WIDTH-1:0]         shifted_c,
    output logic                     shift_out_c
);

    logic [WIDTH-1:0] src;
    logic [WIDTH:0]   ext;

    // Extra top bit captures the last bit pushed out; it stays 0 for amount 0.
    always_comb begin
        src       = '0;
        ext       = '0;
        shifted_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            src[i] = shift_right ? data[int'(WIDTH) - 1 - i] : data[i];
        end
        ext = {1'b0, src} << amount;
        for (int i = 0; i < int'(WIDTH); i++) begin
            shifted_c[i] = shift_right ? ext[int'(WIDTH) - 1 - i] : ext[i];
        end
        shift_out_c = ext[WIDTH];
    end

endmodule

// File: rtl/alu.sv
// Registered 8-operation ALU with optional operand_1 inversion, carry chain and zero flag.
// Define ALU_OVERFLOW_FLAG_EN to add the signed-overflow output for SUM.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] operand_0,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [2:0]       operation,
    input  logic             carry_in,
    input  logic             invert_op_1,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero_flag
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    output logic             overflow_flag
`endif
);

    localparam int unsigned SUMW = WIDTH + 1;
    localparam int unsigned SHW  = $clog2(WIDTH);

    alu_op_e          op;
    logic [WIDTH-1:0] b_prime;
    logic [SUMW-1:0]  sum;
    logic [WIDTH-1:0] shifted;
    logic             shift_out;
    logic             shift_right;
    logic [WIDTH-1:0] next_result;
    logic             next_carry;
    logic             next_zero;
`ifdef ALU_OVERFLOW_FLAG_EN
    logic             next_overflow;
`endif

    assign op          = alu_op_e'(operation);
    assign b_prime     = invert_op_1 ? ~operand_1 : operand_1;
    assign sum         = {1'b0, operand_0} + {1'b0, b_prime} + SUMW'(carry_in);
    assign shift_right = (op == ALU_OP_SHIFT_RIGHT);

    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .data        (operand_0),
        .amount      (b_prime[SHW-1:0]),
        .shift_right (shift_right),
        .shifted_c   (shifted),
        .shift_out_c (shift_out)
    );

    // Next-state decode; every opcode is listed so nothing falls through to X.
    always_comb begin
        next_result = operand_0;
        next_carry  = 1'b0;
        unique case (op)
            ALU_OP_TEST:        next_result = operand_0;
            ALU_OP_SUM: begin
                next_result = sum[WIDTH-1:0];
                next_carry  = sum[WIDTH];
            end
            ALU_OP_AND:         next_result = operand_0 & b_prime;
            ALU_OP_OR:          next_result = operand_0 | b_prime;
            ALU_OP_XOR:         next_result = operand_0 ^ b_prime;
            ALU_OP_SHIFT_LEFT,
            ALU_OP_SHIFT_RIGHT: begin
                next_result = shifted;
                next_carry  = shift_out;
            end
            ALU_OP_NOT:         next_result = ~operand_0;
            default:            next_result = operand_0;
        endcase
        next_zero = (next_result == '0);
    end

`ifdef ALU_OVERFLOW_FLAG_EN
    // Signed overflow: like-signed addends producing a result of the other sign.
    always_comb begin
        next_overflow = 1'b0;
        if (op == ALU_OP_SUM) begin
            next_overflow = (operand_0[WIDTH-1] == b_prime[WIDTH-1]) &&
                            (sum[WIDTH-1] != operand_0[WIDTH-1]);
        end
    end
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            result    <= '0;
            carry_out <= 1'b0;
            zero_flag <= 1'b1;
`ifdef ALU_OVERFLOW_FLAG_EN
            overflow_flag <= 1'b0;
`endif
        end else begin
            result    <= next_result;
            carry_out <= next_carry;
            zero_flag <= next_zero;
`ifdef ALU_OVERFLOW_FLAG_EN
            overflow_flag <= next_overflow;
`endif
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; overflow checks build when ALU_OVERFLOW_FLAG_EN is defined.
module tb_alu;
    import alu_pkg::*;

    logic       clk;
    logic       nrst;
    logic [7:0] operand_0;
    logic [7:0] operand_1;
    logic [2:0] operation;
    logic       carry_in;
    logic       invert_op_1;
    logic [7:0] result;
    logic       carry_out;
    logic       zero_flag;
`ifdef ALU_OVERFLOW_FLAG_EN
    logic       overflow_flag;
`endif

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(8)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .operand_0   (operand_0),
        .operand_1   (operand_1),
        .operation   (operation),
        .carry_in    (carry_in),
        .invert_op_1 (invert_op_1),
        .result      (result),
        .carry_out   (carry_out),
        .zero_flag   (zero_flag)
`ifdef ALU_OVERFLOW_FLAG_EN
        ,
        .overflow_flag (overflow_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs after a falling edge, then settle just past the next rising edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic inv, input logic cin);
        @(negedge clk);
        operand_0   = a;
        operand_1   = b;
        operation   = op;
        invert_op_1 = inv;
        carry_in    = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            operand_0   = 8'($urandom);
            operand_1   = 8'($urandom);
            operation   = 3'($urandom);
            carry_in    = 1'($urandom);
            invert_op_1 = 1'($urandom);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({result, carry_out, zero_flag} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold got r=%h c=%b z=%b want r=00 c=0 z=1",
                     result, carry_out, zero_flag);
        end
`ifdef ALU_OVERFLOW_FLAG_EN
        checks++;
        if (overflow_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b want 0", overflow_flag);
        end
`endif
        @(negedge clk);
        nrst = 1'b1;
        drive(8'hF0, 8'h0F, 3'(ALU_OP_SUM), 1'b0, 1'b1);
        checks++;
        if ({result, carry_out, zero_flag} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL first_after_reset got r=%h c=%b z=%b want r=00 c=1 z=1",
                     result, carry_out, zero_flag);
        end
        drive(8'h5C, 8'h00, 3'(ALU_OP_NOT), 1'b0, 1'b0);
        // Asynchronous clear away from any clock edge.
        #2;
        nrst = 1'b0;
        #1;
        checks++;
        if ({result, carry_out, zero_flag} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_async got r=%h c=%b z=%b want r=00 c=0 z=1",
                     result, carry_out, zero_flag);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_opcodes();
        logic [7:0] exp_r [8];
        logic       exp_c [8];
        exp_r = '{8'hAA, 8'h9A, 8'hA0, 8'hFA, 8'h5A, 8'hAA, 8'hAA, 8'h55};
        exp_c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(8'hAA, 8'hF0, 3'(i), 1'b0, 1'b0);
            checks++;
            if ({result, carry_out, zero_flag} !== {exp_r[i], exp_c[i], 1'b0}) begin
                errors++;
                $display("FAIL opcode_%0d got r=%h c=%b z=%b want r=%h c=%b z=0",
                         i, result, carry_out, zero_flag, exp_r[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_sum();
        logic [7:0] exp_r [3];
        logic       exp_c [3];
        logic       inv   [3];
        logic       cin   [3];
        exp_r = '{8'hBA, 8'h9B, 8'h9A};
        exp_c = '{1'b0, 1'b1, 1'b1};
        inv   = '{1'b1, 1'b0, 1'b0};
        cin   = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(8'hAA, 8'hF0, 3'(ALU_OP_SUM), inv[i], cin[i]);
            checks++;
            if ({result, carry_out, zero_flag} !== {exp_r[i], exp_c[i], 1'b0}) begin
                errors++;
                $display("FAIL sum_%0d got r=%h c=%b z=%b want r=%h c=%b z=0",
                         i, result, carry_out, zero_flag, exp_r[i], exp_c[i]);
            end
        end
        drive(8'h10, 8'h10, 3'(ALU_OP_SUM), 1'b1, 1'b1);
        checks++;
        if ({result, carry_out, zero_flag} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_equal got r=%h c=%b z=%b want r=00 c=1 z=1",
                     result, carry_out, zero_flag);
        end
    endtask

    task automatic test_shift();
        logic [7:0] b     [5];
        logic [2:0] op    [5];
        logic       inv   [5];
        logic [7:0] exp_r [5];
        logic       exp_c [5];
        b     = '{8'h01, 8'h01, 8'h07, 8'hFE, 8'hF9};
        op    = '{3'(ALU_OP_SHIFT_LEFT), 3'(ALU_OP_SHIFT_RIGHT), 3'(ALU_OP_SHIFT_LEFT),
                  3'(ALU_OP_SHIFT_LEFT), 3'(ALU_OP_SHIFT_RIGHT)};
        inv   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        // Last two: inverted amount 0xFE->1, and 0xF9 ignores upper bits -> amount 1.
        exp_r = '{8'h02, 8'h40, 8'h80, 8'h02, 8'h40};
        exp_c = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(8'h81, b[i], op[i], inv[i], 1'b1);
            checks++;
            if ({result, carry_out, zero_flag} !== {exp_r[i], exp_c[i], 1'b0}) begin
                errors++;
                $display("FAIL shift_%0d got r=%h c=%b z=%b want r=%h c=%b z=0",
                         i, result, carry_out, zero_flag, exp_r[i], exp_c[i]);
            end
        end
        drive(8'h81, 8'h07, 3'(ALU_OP_SHIFT_RIGHT), 1'b0, 1'b0);
        checks++;
        if ({result, carry_out, zero_flag} !== {8'h01, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL shr_7 got r=%h c=%b z=%b want r=01 c=0 z=0",
                     result, carry_out, zero_flag);
        end
    endtask

    task automatic test_logic_zero();
        drive(8'hAA, 8'h55, 3'(ALU_OP_AND), 1'b0, 1'b1);
        checks++;
        if ({result, carry_out, zero_flag} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL and_zero got r=%h c=%b z=%b want r=00 c=0 z=1",
                     result, carry_out, zero_flag);
        end
        drive(8'hAA, 8'hAA, 3'(ALU_OP_XOR), 1'b1, 1'b1);
        checks++;
        if ({result, carry_out, zero_flag} !== {8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL xor_inv got r=%h c=%b z=%b want r=ff c=0 z=0",
                     result, carry_out, zero_flag);
        end
        drive(8'hFF, 8'h00, 3'(ALU_OP_NOT), 1'b0, 1'b1);
        checks++;
        if ({result, carry_out, zero_flag} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL not_zero got r=%h c=%b z=%b want r=00 c=0 z=1",
                     result, carry_out, zero_flag);
        end
    endtask

    task automatic test_latency();
        drive(8'h3C, 8'h00, 3'(ALU_OP_TEST), 1'b0, 1'b0);
        @(negedge clk);
        operand_0 = 8'hC3;
        #2;
        checks++;
        if (result !== 8'h3C) begin
            errors++;
            $display("FAIL latency_hold got r=%h want r=3c", result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (result !== 8'hC3) begin
            errors++;
            $display("FAIL latency_update got r=%h want r=c3", result);
        end
    endtask

`ifdef ALU_OVERFLOW_FLAG_EN
    task automatic test_overflow();
        drive(8'h7F, 8'h01, 3'(ALU_OP_SUM), 1'b0, 1'b0);
        checks++;
        if ({result, carry_out, zero_flag, overflow_flag} !== {8'h80, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_pos got r=%h c=%b z=%b v=%b want r=80 c=0 z=0 v=1",
                     result, carry_out, zero_flag, overflow_flag);
        end
        drive(8'hFF, 8'h01, 3'(ALU_OP_SUM), 1'b0, 1'b0);
        checks++;
        if ({result, carry_out, zero_flag, overflow_flag} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ovf_wrap got r=%h c=%b z=%b v=%b want r=00 c=1 z=1 v=0",
                     result, carry_out, zero_flag, overflow_flag);
        end
        drive(8'h7F, 8'h01, 3'(ALU_OP_OR), 1'b0, 1'b0);
        checks++;
        if (overflow_flag !== 1'b0) begin
            errors++;
            $display("FAIL ovf_non_sum got v=%b want v=0", overflow_flag);
        end
    endtask
`endif

    initial begin
        nrst        = 1'b0;
        operand_0   = '0;
        operand_1   = '0;
        operation   = '0;
        carry_in    = 1'b0;
        invert_op_1 = 1'b0;
        test_reset();
        test_opcodes();
        test_sum();
        test_shift();
        test_logic_zero();
        test_latency();
`ifdef ALU_OVERFLOW_FLAG_EN
        test_overflow();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
